// File: rtl/cp0_exc_ctrl.sv
// MIPS CP0 subset: exception/eret sequencing, timer interrupt, and mfc0/mtc0 access.
// Commit-stage events are prioritised exc_valid > eret > mtc0; flush/new_pc are registered.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_ENTRY    = 32'hBFC0_0380,
   parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret,
   input  logic [5:0]  ext_int,
   output logic        int_req,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] epc_o
);

   localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
   localparam logic [4:0]  ADDR_COUNT    = 5'd9;
   localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
   localparam logic [4:0]  ADDR_STATUS   = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
   localparam logic [4:0]  ADDR_EPC      = 5'd14;

   localparam logic [31:0] STATUS_MASK  = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_MASK   = 32'h0000_0300;
   localparam logic [31:0] STATUS_CONST = 32'h0040_0000;

   logic [31:0] status_r;
   logic [31:0] cause_r;
   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic [31:0] epc_r;
   logic [31:0] badvaddr_r;
   logic        tick_r;
   logic        flush_r;
   logic [31:0] new_pc_r;

   logic        we_acc;
   logic        eret_acc;
   logic [31:0] status_rd;
   logic [31:0] rd_cur;
   logic [31:0] rd_mask;

   assign we_acc    = cp0_we & ~exc_valid & ~eret;
   assign eret_acc  = eret & ~exc_valid;
   assign status_rd = status_r | STATUS_CONST;

   assign int_req = status_r[0] & ~status_r[1] & (|(cause_r[15:8] & status_r[15:8]));
   assign flush   = flush_r;
   assign new_pc  = new_pc_r;
   assign epc_o   = epc_r;

   // Read mux; a same-cycle accepted mtc0 to the read address is merged through its write mask.
   always_comb begin
      rd_cur  = '0;
      rd_mask = '0;
      case (cp0_raddr)
         ADDR_BADVADDR: begin rd_cur = badvaddr_r; rd_mask = '0;          end
         ADDR_COUNT:    begin rd_cur = count_r;    rd_mask = '1;          end
         ADDR_COMPARE:  begin rd_cur = compare_r;  rd_mask = '1;          end
         ADDR_STATUS:   begin rd_cur = status_rd;  rd_mask = STATUS_MASK; end
         ADDR_CAUSE:    begin rd_cur = cause_r;    rd_mask = CAUSE_MASK;  end
         ADDR_EPC:      begin rd_cur = epc_r;      rd_mask = '1;          end
         default:       begin rd_cur = '0;         rd_mask = '0;          end
      endcase
      cp0_rdata = rd_cur;
      if (we_acc && (cp0_waddr == cp0_raddr))
         cp0_rdata = (rd_cur & ~rd_mask) | (cp0_wdata & rd_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_r   <= RESET_STATUS;
         cause_r    <= '0;
         count_r    <= '0;
         compare_r  <= '0;
         epc_r      <= '0;
         badvaddr_r <= '0;
         tick_r     <= 1'b0;
         flush_r    <= 1'b0;
         new_pc_r   <= '0;
      end else begin
         tick_r  <= ~tick_r;
         flush_r <= exc_valid | eret;

         if (exc_valid)
            new_pc_r <= EXC_ENTRY;
         else if (eret)
            new_pc_r <= epc_r;

         if (we_acc && (cp0_waddr == ADDR_COUNT))
            count_r <= cp0_wdata;
         else if (tick_r)
            count_r <= count_r + 32'd1;

         if (we_acc && (cp0_waddr == ADDR_COMPARE))
            compare_r <= cp0_wdata;

         // Timer interrupt is sticky until Compare is rewritten; the clear wins over a new match.
         if (we_acc && (cp0_waddr == ADDR_COMPARE))
            cause_r[30] <= 1'b0;
         else if (count_r == compare_r)
            cause_r[30] <= 1'b1;

         cause_r[15:10] <= {ext_int[5] | cause_r[30], ext_int[4:0]};

         if (we_acc && (cp0_waddr == ADDR_CAUSE))
            cause_r[9:8] <= cp0_wdata[9:8];

         if (we_acc && (cp0_waddr == ADDR_STATUS))
            status_r <= (status_r & ~STATUS_MASK) | (cp0_wdata & STATUS_MASK);

         if (we_acc && (cp0_waddr == ADDR_EPC))
            epc_r <= cp0_wdata;

         if (exc_valid) begin
            status_r[1]  <= 1'b1;
            cause_r[6:2] <= exc_code;
            if (!status_r[1]) begin
               cause_r[31] <= exc_bd;
               epc_r       <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end
            if ((exc_code == 5'd4) || (exc_code == 5'd5))
               badvaddr_r <= exc_badvaddr;
         end else if (eret_acc) begin
            status_r[1] <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_ENTRY, default 32'hBFC0_0380, exception vector driven on new_pc.
REQ-002 SHALL have parameter RESET_STATUS, default 32'h0040_0000, Status reset value (BEV=1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cp0_raddr  in  5  mfc0 source register number (rd field).
REQ-006 cp0_rdata  out  32  mfc0 read data, combinational.
REQ-007 cp0_we  in  1  mtc0 commit strobe.
REQ-008 cp0_waddr  in  5  mtc0 destination register number.
REQ-009 cp0_wdata  in  32  mtc0 write data.
REQ-010 exc_valid  in  1  exception taken at commit stage.
REQ-011 exc_code  in  5  ExcCode of the faulting instruction.
REQ-012 exc_pc  in  32  PC of the faulting instruction.
REQ-013 exc_bd  in  1  faulting instruction sits in a branch delay slot.
REQ-014 exc_badvaddr  in  32  faulting address for AdEL/AdES.
REQ-015 eret  in  1  eret commit strobe.
REQ-016 ext_int  in  6  hardware interrupt lines, level-sensitive.
REQ-017 int_req  out  1  interrupt pending, to commit stage.
REQ-018 flush  out  1  pipeline flush pulse.
REQ-019 new_pc  out  32  redirect target, valid while flush=1.
REQ-020 epc_o  out  32  current EPC value.

Function
REQ-021 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other address reads 32'h0, writes ignored.
REQ-022 SHALL use writable masks: Status bits [15:8],[1],[0]; Cause bits [9:8]; Count, Compare, EPC all 32 bits; BadVAddr read-only; Status[22] constant 1.
REQ-023 SHALL keep a 1-bit tick toggling every cycle; Count increments by 1 on cycles where tick=1, wraps 32'hFFFF_FFFF -> 0.
REQ-024 SHALL give an mtc0 to Count precedence over that cycle's increment.
REQ-025 SHALL set Cause.TI(bit 30) in the cycle after Count==Compare; mtc0 to Compare SHALL clear TI, taking precedence over setting.
REQ-026 SHALL register Cause.IP[15:10] each cycle as {ext_int[5]|TI, ext_int[4:0]}.
REQ-027 int_req SHALL equal Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), from registered state.
REQ-028 Same-cycle priority: exc_valid > eret > cp0_we; a lower-priority event is discarded entirely.
REQ-029 On exc_valid with EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause.BD(bit 31) <= exc_bd.
REQ-030 On exc_valid with EXL=1: EPC and Cause.BD SHALL be unchanged.
REQ-031 On exc_valid always: EXL <= 1; Cause[6:2] <= exc_code; BadVAddr <= exc_badvaddr only when exc_code is 4 or 5.
REQ-032 On eret: EXL <= 0.
REQ-033 flush SHALL be registered: 1 for exactly one cycle following an accepted exc_valid or eret, else 0.
REQ-034 new_pc SHALL be registered with flush: EXC_ENTRY after exception; after eret, the EPC value held in the eret cycle.
REQ-035 cp0_rdata SHALL forward a same-cycle accepted mtc0 to the same address, applying writable masks.
REQ-036 Back-to-back exc_valid on consecutive cycles SHALL each be processed; flush stays 1 for both following cycles.

Reset
REQ-037 On rst=1 at a clock edge: Status=RESET_STATUS, Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0, tick=0, flush=0, new_pc=0; all inputs ignored that cycle.
REQ-038 rst mid-operation SHALL cancel a pending flush; flush=0 in the cycle after reset.

Verification
REQ-039 Exception in delay slot: EXL=0, exc_valid=1, exc_pc=32'h8000_0104, exc_bd=1, exc_code=4, exc_badvaddr=32'h1 -> next cycle flush=1, new_pc=32'hBFC0_0380, EPC=32'h8000_0100, Cause.BD=1, Cause[6:2]=4, BadVAddr=32'h1, Status.EXL=1.
REQ-040 Nested exception: EXL=1, exc_valid with exc_pc=32'h8000_0200 -> EPC unchanged, ExcCode updated, flush pulses.
REQ-041 eret: EPC=32'h8000_0100, eret=1 -> next cycle flush=1, new_pc=32'h8000_0100, EXL=0; flush=0 the cycle after.
REQ-042 Timer: mtc0 Compare=5, Count=0 -> Count reaches 5 after 10 cycles, TI=1 next cycle; with Status=32'h0040_8001, int_req=1; mtc0 Compare clears TI and int_req.
REQ-043 Priority: exc_valid=1, eret=1, cp0_we=1 to Status together -> exception applied only, Status write dropped, new_pc=EXC_ENTRY.
REQ-044 Reset mid-flush: exc_valid in cycle n, rst in cycle n+1 -> flush=0, Status=32'h0040_0000 in cycle n+2.
